// File: rtl/seq_nibble_adder_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial adder controller.
package seq_nibble_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Four-bit ripple-carry adder, the single shared datapath of the controller.
module ripple_carry_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic       Cout
);

  logic c;

  // Bit-serial full-adder chain, LSB first.
  always_comb begin
    c    = Cin;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    Cout = c;
  end

endmodule

// File: rtl/seq_nibble_adder_ctrl.sv
// Nibble-serial adder: one shared 4-bit adder reused NIBBLES times per add,
// carry held in a flop between passes so no carry path exceeds 4 bits.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; sum/Cout hold the last result
// RUN     | one nibble per cycle, LSB first; sum partially updated
// DONE    | result valid for one cycle; start here begins the next add
module seq_nibble_adder_ctrl
  import seq_nibble_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t               state_q, state_d;
  logic                 accept;
  logic                 last_nib;
  logic [IDX_W-1:0]     idx;
  logic                 carry_q;
  logic                 cout_q;
  logic [WIDTH-1:0]     a_reg, b_reg, sum_reg;
  logic [NIBBLE_W-1:0]  a_nib, b_nib, add_sum;
  logic                 add_cout;

  assign last_nib = (idx == IDX_LAST);
  assign a_nib    = a_reg[NIBBLE_W*idx +: NIBBLE_W];
  assign b_nib    = b_reg[NIBBLE_W*idx +: NIBBLE_W];

  ripple_carry_adder_4bit u_rca (
    .A    (a_nib),
    .B    (b_nib),
    .Cin  (carry_q),
    .sum  (add_sum),
    .Cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_nib) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, nibble index, inter-nibble carry and result assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B;
      carry_q <= Cin;
      idx     <= '0;
    end else if (state_q == ST_RUN) begin
      sum_reg[NIBBLE_W*idx +: NIBBLE_W] <= add_sum;
      carry_q <= add_cout;
      if (last_nib) begin
        cout_q <= add_cout;
        idx    <= '0;
      end else begin
        idx    <= idx + IDX_W'(1);
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_reg;
  assign Cout = cout_q;

endmodule

// File: tb/tb_seq_nibble_adder_ctrl.sv
// Bench for the nibble-serial adder: directed cases on WIDTH=16 plus a
// random regression driving WIDTH=4, 8 and 16 instances in parallel.
module tb_seq_nibble_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;

  logic        busy4, done4, cout4;
  logic [3:0]  sum4;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_nibble_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .Cout(cout16)
  );

  seq_nibble_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .A(a[7:0]), .B(b[7:0]), .Cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .Cout(cout8)
  );

  seq_nibble_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .A(a[3:0]), .B(b[3:0]), .Cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .Cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands with start, let one edge accept them, then scramble
  // the inputs so only the captured copies can produce the right answer.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    cin   = 1'($urandom);
  endtask

  // Follow the 16-bit instance through RUN into DONE; optionally poke a
  // second start mid-RUN that must be ignored.
  task automatic watch(input string tag, input logic [15:0] es, input logic ec, input bit mid);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy16), 32'(c <= 4));
      chk({tag, "_done"}, 32'(done16), 32'(c == 5));
      if (mid) begin
        if (c == 2) begin
          start = 1'b1;
          a     = 16'hFFFF;
        end else begin
          start = 1'b0;
        end
      end
    end
    chk({tag, "_sum"},  32'(sum16),  32'(es));
    chk({tag, "_cout"}, 32'(cout16), 32'(ec));
  endtask

  initial begin
    int r4, r8, r16;
    logic [15:0] ra, rb;
    logic        rc;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    chk("reset_sum",  32'(sum16),  32'h0);
    chk("reset_cout", 32'(cout16), 32'h0);
    chk("reset_busy", 32'(busy16), 32'h0);
    chk("reset_done", 32'(done16), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    issue(16'h1234, 16'h4321, 1'b0);
    watch("basic", 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0);
    watch("ripple", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    issue(16'hFFFF, 16'h0000, 1'b1);
    watch("cin_ripple", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    issue(16'h8000, 16'h8000, 1'b1);
    watch("msb_carry", 16'h0001, 1'b1, 1'b0);

    @(negedge clk);
    issue(16'h0F0F, 16'h00F1, 1'b0);
    watch("mid_start", 16'h1000, 1'b0, 1'b1);
    // Still in the DONE cycle here: back-to-back start.
    issue(16'h0001, 16'h0001, 1'b0);
    watch("b2b", 16'h0002, 1'b0, 1'b0);

    @(negedge clk);
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_partial", 32'(sum16), 32'h0003);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sum",  32'(sum16),  32'h0);
    chk("async_rst_cout", 32'(cout16), 32'h0);
    chk("async_rst_busy", 32'(busy16), 32'h0);
    chk("async_rst_done", 32'(done16), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0003, 16'h0004, 1'b0);
    watch("after_rst", 16'h0007, 1'b0, 1'b0);

    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      r4  = int'(ra[3:0]) + int'(rb[3:0]) + int'(rc);
      r8  = int'(ra[7:0]) + int'(rb[7:0]) + int'(rc);
      r16 = int'(ra) + int'(rb) + int'(rc);
      issue(ra, rb, rc);
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        chk("rnd_busy4",  32'(busy4),  32'(c <= 1));
        chk("rnd_done4",  32'(done4),  32'(c == 2));
        chk("rnd_busy8",  32'(busy8),  32'(c <= 2));
        chk("rnd_done8",  32'(done8),  32'(c == 3));
        chk("rnd_busy16", 32'(busy16), 32'(c <= 4));
        chk("rnd_done16", 32'(done16), 32'(c == 5));
        if (c == 2) chk("rnd_sum4",  32'({cout4, sum4}),   32'(r4));
        if (c == 3) chk("rnd_sum8",  32'({cout8, sum8}),   32'(r8));
        if (c == 5) chk("rnd_sum16", 32'({cout16, sum16}), 32'(r16));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
